// File: rtl/pong_pkg.sv
// Shared types and constants for the ball/rally engine.
//   state_t    : rally sequencing states (IDLE, SERVE, PLAY, POINT, OVER)
//   speed_t    : per-frame ball step {sx, sy}
//   SPEED_LUT  : speed per level, latched when a serve launches
//   zone_t     : which quarter of a paddle the ball struck
//   zone_outer : true for the two edge quarters, which steepen the bounce
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    typedef struct packed {
        logic [3:0] sx;
        logic [3:0] sy;
    } speed_t;

    localparam speed_t SPEED_LUT [4] = '{
        '{4'd2, 4'd1},
        '{4'd3, 4'd1},
        '{4'd3, 4'd2},
        '{4'd4, 4'd3}
    };

    typedef enum logic [1:0] {
        ZONE_TOP_OUT,
        ZONE_TOP_IN,
        ZONE_BOT_IN,
        ZONE_BOT_OUT
    } zone_t;

    function automatic logic zone_outer(input zone_t z);
        return (z == ZONE_TOP_OUT) || (z == ZONE_BOT_OUT);
    endfunction

endpackage

// File: rtl/ball_engine_paddle_zone.sv
// Combinational paddle contact test for one paddle.
//   ball_y   in  W  top row of the ball (already moved for this frame)
//   paddle_y in  W  top row of the paddle
//   overlap  out 1  any ball row lies within the paddle's rows
//   zone     out    paddle quarter struck, measured from the ball's top row
module paddle_zone
    import pong_pkg::*;
#(
    parameter int W       = 10,
    parameter int BALL_SZ = 4,
    parameter int PAD_H   = 48
) (
    input  logic [W-1:0] ball_y,
    input  logic [W-1:0] paddle_y,
    output logic         overlap,
    output zone_t        zone
);

    localparam int QUARTER = PAD_H / 4;

    int by;
    int py;
    int offset;

    always_comb begin
        by      = int'(ball_y);
        py      = int'(paddle_y);
        offset  = by - py;
        overlap = (by + BALL_SZ - 1 >= py) && (by <= py + PAD_H - 1);
        // A ball clipping the paddle from above has a negative offset and
        // counts as the top edge quarter.
        if (offset < QUARTER) begin
            zone = ZONE_TOP_OUT;
        end else if (offset < 2 * QUARTER) begin
            zone = ZONE_TOP_IN;
        end else if (offset < 3 * QUARTER) begin
            zone = ZONE_BOT_IN;
        end else begin
            zone = ZONE_BOT_OUT;
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Ball/rally engine for a two-paddle game: ball position and direction,
// per-frame motion, wall and paddle collisions, paddle-zone deflection,
// scoring and serve sequencing. State advances once per frame_tick.
// Optional feature macro: BALL_SPEEDUP_EN (every 4 paddle hits in a rally
// add 1 to the x speed, up to +3; counter cleared at each serve).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   frame_tick          one-cycle pulse per frame
//   start               begins a game from IDLE or OVER
//   serve_dir           first-serve x direction (1 = toward P2)
//   level               speed level, latched when a serve launches
//   paddle_y1/2         top row of left/right paddle
//   ball_x/y            top-left of ball (registered)
//   right, down         current direction
//   score1/2            points for P1/P2
//   point_p1/p2         one-cycle pulse when a point is awarded
//   game_over           high while in OVER
module ball_engine
    import pong_pkg::*;
#(
    parameter int H_RES        = 800,
    parameter int V_RES        = 600,
    parameter int W            = 10,
    parameter int BALL_SZ      = 4,
    parameter int PAD_H        = 48,
    parameter int P1_X         = 38,
    parameter int P2_X         = 756,
    parameter int SERVE_FRAMES = 60,
    parameter int MAX_SCORE    = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         serve_dir,
    input  logic [1:0]   level,
    input  logic [W-1:0] paddle_y1,
    input  logic [W-1:0] paddle_y2,
    output logic [W-1:0] ball_x,
    output logic [W-1:0] ball_y,
    output logic         right,
    output logic         down,
    output logic [3:0]   score1,
    output logic [3:0]   score2,
    output logic         point_p1,
    output logic         point_p2,
    output logic         game_over
);

    localparam int           X_MAX    = H_RES - BALL_SZ;
    localparam int           Y_MAX    = V_RES - BALL_SZ;
    localparam logic [W-1:0] X_CTR    = W'((H_RES - BALL_SZ) / 2);
    localparam logic [W-1:0] Y_CTR    = W'((V_RES - BALL_SZ) / 2);
    localparam int           HIT_SPAN = 6;
    localparam int           CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] frame_cnt;
    speed_t           spd;
    logic [3:0]       dy;
    logic [3:0]       sx_eff;
    logic             scorer_p2;

    int               x_try;
    int               y_try;
    logic [W-1:0]     x_new;
    logic [W-1:0]     y_new;
    logic             down_wall;
    logic             down_next;
    logic             right_next;
    logic [3:0]       dy_next;
    logic             ov1;
    logic             ov2;
    zone_t            zone1;
    zone_t            zone2;
    zone_t            zone_hit;
    logic             hit1;
    logic             hit2;
    logic             hit;
    logic             score_p1;
    logic             score_p2;
    logic             serve_done;
    logic             game_end;
    logic             start_game;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (int'(s) >= MAX_SCORE) ? s : s + 4'd1;
    endfunction

    // Speed for this rally: level entry plus optional rally speed-up.
`ifdef BALL_SPEEDUP_EN
    logic [1:0] hit_cnt;
    logic [1:0] boost;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= 2'd0;
            boost   <= 2'd0;
        end else if (start_game || state == POINT) begin
            hit_cnt <= 2'd0;
            boost   <= 2'd0;
        end else if (state == PLAY && frame_tick && hit) begin
            hit_cnt <= hit_cnt + 2'd1;
            // Fourth hit of each group of four raises the boost.
            if (hit_cnt == 2'd3 && boost != 2'd3) begin
                boost <= boost + 2'd1;
            end
        end
    end

    assign sx_eff = spd.sx + {2'b00, boost};
`else
    assign sx_eff = spd.sx;
`endif

    assign start_game = start && (state == IDLE || state == OVER);
    assign serve_done = (frame_cnt == CNT_LAST);
    assign game_end   = scorer_p2 ? (int'(score2) + 1 >= MAX_SCORE)
                                  : (int'(score1) + 1 >= MAX_SCORE);
    assign game_over  = (state == OVER);

    // Candidate position for the next frame, clamped to the playfield.
    always_comb begin
        y_try     = down ? int'(ball_y) + int'(dy) : int'(ball_y) - int'(dy);
        down_wall = down;
        if (y_try >= Y_MAX) begin
            y_try     = Y_MAX;
            down_wall = 1'b0;
        end else if (y_try <= 0) begin
            y_try     = 0;
            down_wall = 1'b1;
        end
        x_try = right ? int'(ball_x) + int'(sx_eff) : int'(ball_x) - int'(sx_eff);
        if (x_try > X_MAX) begin
            x_try = X_MAX;
        end else if (x_try < 0) begin
            x_try = 0;
        end
    end

    assign y_new = W'(y_try);
    assign x_new = W'(x_try);

    paddle_zone #(.W(W), .BALL_SZ(BALL_SZ), .PAD_H(PAD_H)) u_zone1 (
        .ball_y   (y_new),
        .paddle_y (paddle_y1),
        .overlap  (ov1),
        .zone     (zone1)
    );

    paddle_zone #(.W(W), .BALL_SZ(BALL_SZ), .PAD_H(PAD_H)) u_zone2 (
        .ball_y   (y_new),
        .paddle_y (paddle_y2),
        .overlap  (ov2),
        .zone     (zone2)
    );

    // Paddle hit outranks scoring; a wall bounce in the same frame is kept
    // unless an edge-zone hit redirects the ball away from paddle centre.
    always_comb begin
        hit1 = !right && (int'(x_new) >= P1_X) && (int'(x_new) <= P1_X + HIT_SPAN) && ov1;
        hit2 = right && (int'(x_new) >= P2_X) && (int'(x_new) <= P2_X + HIT_SPAN) && ov2;
        hit  = hit1 || hit2;
        zone_hit   = hit1 ? zone1 : zone2;
        right_next = right;
        down_next  = down_wall;
        dy_next    = dy;
        if (hit) begin
            right_next = !right;
            if (zone_outer(zone_hit)) begin
                dy_next   = spd.sy + 4'd1;
                down_next = (zone_hit == ZONE_BOT_OUT);
            end else begin
                dy_next = spd.sy;
            end
        end
        score_p2 = !hit && !right && (x_new == '0);
        score_p1 = !hit && right && (int'(x_new) == X_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, OVER: if (start) state_n = SERVE;
            SERVE:      if (frame_tick && serve_done) state_n = PLAY;
            PLAY:       if (frame_tick && (score_p1 || score_p2)) state_n = POINT;
            POINT:      state_n = game_end ? OVER : SERVE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ball_x    <= X_CTR;
            ball_y    <= Y_CTR;
            right     <= serve_dir;
            down      <= 1'b1;
            dy        <= SPEED_LUT[0].sy;
            spd       <= SPEED_LUT[0];
            frame_cnt <= '0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            scorer_p2 <= 1'b0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        ball_x    <= X_CTR;
                        ball_y    <= Y_CTR;
                        right     <= serve_dir;
                        down      <= 1'b1;
                        frame_cnt <= '0;
                        score1    <= 4'd0;
                        score2    <= 4'd0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (serve_done) begin
                            spd <= SPEED_LUT[level];
                            dy  <= SPEED_LUT[level].sy;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        ball_x <= x_new;
                        ball_y <= y_new;
                        right  <= right_next;
                        down   <= down_next;
                        dy     <= dy_next;
                        if (score_p1 || score_p2) begin
                            scorer_p2 <= score_p2;
                        end
                    end
                end
                POINT: begin
                    if (scorer_p2) begin
                        score2   <= sat_inc(score2);
                        point_p2 <= 1'b1;
                    end else begin
                        score1   <= sat_inc(score1);
                        point_p1 <= 1'b1;
                    end
                    // Next serve heads toward the player who conceded.
                    right     <= !scorer_p2;
                    ball_x    <= X_CTR;
                    ball_y    <= Y_CTR;
                    down      <= 1'b1;
                    frame_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
module tb_ball_engine;

    localparam int XMAX = 796;
    localparam int YMAX = 596;
    localparam int CX   = 398;
    localparam int CY   = 298;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic       serve_dir;
    logic [1:0] level;
    logic [9:0] paddle_y1;
    logic [9:0] paddle_y2;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       right;
    logic       down;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       point_p1;
    logic       point_p2;
    logic       game_over;

    ball_engine dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .serve_dir  (serve_dir),
        .level      (level),
        .paddle_y1  (paddle_y1),
        .paddle_y2  (paddle_y2),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .right      (right),
        .down       (down),
        .score1     (score1),
        .score2     (score2),
        .point_p1   (point_p1),
        .point_p2   (point_p2),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: game rules evaluated with plain integers.
    // mode: 0 idle, 1 serve, 2 play, 3 point, 4 over
    int m_mode, m_x, m_y, m_dy, m_sx, m_sy, m_cnt, m_s1, m_s2, m_hits;
    bit m_r, m_d, m_p1, m_p2, m_last_p2;
    int lut_sx [4] = '{2, 3, 3, 4};
    int lut_sy [4] = '{1, 1, 2, 3};

    task automatic m_centre();
        m_x = CX; m_y = CY; m_d = 1'b1; m_cnt = 0; m_hits = 0;
    endtask

    task automatic play_frame();
        int sx, nx, ny, py, zone;
        bit nd, hit;
        sx = m_sx;
`ifdef BALL_SPEEDUP_EN
        sx = sx + ((m_hits / 4 > 3) ? 3 : m_hits / 4);
`endif
        ny = m_d ? m_y + m_dy : m_y - m_dy;
        nd = m_d;
        if (ny >= YMAX) begin ny = YMAX; nd = 1'b0; end
        else if (ny <= 0) begin ny = 0; nd = 1'b1; end
        nx = m_r ? m_x + sx : m_x - sx;
        if (nx > XMAX) nx = XMAX;
        if (nx < 0) nx = 0;
        hit = 1'b0;
        py  = 0;
        if (!m_r && nx >= 38 && nx <= 44) begin
            py  = int'(paddle_y1);
            hit = (ny + 3 >= py) && (ny <= py + 47);
        end
        if (m_r && nx >= 756 && nx <= 762) begin
            py  = int'(paddle_y2);
            hit = (ny + 3 >= py) && (ny <= py + 47);
        end
        if (hit) begin
            zone = (ny < py) ? 0 : (ny - py) / 12;
            if (zone > 3) zone = 3;
            if (zone == 0) begin m_dy = m_sy + 1; nd = 1'b0; end
            else if (zone == 3) begin m_dy = m_sy + 1; nd = 1'b1; end
            else m_dy = m_sy;
            m_r = !m_r;
            m_hits++;
        end else if (!m_r && nx == 0) begin
            m_mode = 3; m_last_p2 = 1'b1;
        end else if (m_r && nx == XMAX) begin
            m_mode = 3; m_last_p2 = 1'b0;
        end
        m_x = nx; m_y = ny; m_d = nd;
    endtask

    task automatic model_step();
        m_p1 = 1'b0;
        m_p2 = 1'b0;
        if (rst) begin
            m_mode = 0; m_centre(); m_r = serve_dir; m_s1 = 0; m_s2 = 0;
        end else begin
            case (m_mode)
                0, 4: if (start) begin
                    m_mode = 1; m_centre(); m_r = serve_dir; m_s1 = 0; m_s2 = 0;
                end
                1: if (frame_tick) begin
                    m_cnt++;
                    if (m_cnt == 60) begin
                        m_mode = 2; m_sx = lut_sx[level]; m_sy = lut_sy[level]; m_dy = m_sy;
                    end
                end
                2: if (frame_tick) play_frame();
                default: begin
                    if (m_last_p2) begin if (m_s2 < 7) m_s2++; m_p2 = 1'b1; end
                    else begin if (m_s1 < 7) m_s1++; m_p1 = 1'b1; end
                    m_mode = ((m_last_p2 ? m_s2 : m_s1) >= 7) ? 4 : 1;
                    m_centre();
                    m_r = !m_last_p2;
                end
            endcase
        end
    endtask

    task automatic check_model();
        chk("mdl.ball_x", ball_x, m_x);
        chk("mdl.ball_y", ball_y, m_y);
        chk("mdl.right", right, m_r);
        chk("mdl.down", down, m_d);
        chk("mdl.score1", score1, m_s1);
        chk("mdl.score2", score2, m_s2);
        chk("mdl.point_p1", point_p1, m_p1);
        chk("mdl.point_p2", point_p2, m_p2);
        chk("mdl.game_over", game_over, m_mode == 4);
    endtask

    task automatic step(input bit r, input bit st, input bit tk, input bit sd,
                        input int lvl, input int p1, input int p2);
        rst = r; start = st; frame_tick = tk; serve_dir = sd;
        level = lvl[1:0]; paddle_y1 = p1[9:0]; paddle_y2 = p2[9:0];
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        int n, rst, start, tick, sdir, lvl, py1, py2;
        int ex, ey, er, ed, s1, s2, pp1, pp2, go;
    } vec_t;

    vec_t vecs [20];

    initial begin
        bit r, st, tk, sd;
        int lvl, p1, p2;

        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; serve_dir = 1'b0;
        level = 2'd0; paddle_y1 = '0; paddle_y2 = '0;

        //        n   rs st tk sd lv py1  py2   x    y   r  d  s1 s2 p1 p2 go
        vecs = '{
            '{  1, 1, 0, 0, 1, 0,   0, 0, 398, 298, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 1, 0, 1, 0,   0, 0, 398, 298, 1, 1, 0, 0, 0, 0, 0},
            '{ 59, 0, 0, 1, 1, 0,   0, 0, 398, 298, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 1, 0,   0, 0, 398, 298, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 1, 0,   0, 0, 400, 299, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 1, 1, 1, 0,   0, 0, 402, 300, 1, 1, 0, 0, 0, 0, 0},
            '{197, 0, 0, 1, 1, 0,   0, 0, 796, 497, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 1, 0,   0, 0, 398, 298, 1, 1, 1, 0, 1, 0, 0},
            '{  1, 0, 0, 0, 1, 0,   0, 0, 398, 298, 1, 1, 1, 0, 0, 0, 0},
            '{ 60, 0, 0, 1, 1, 3,   0, 0, 398, 298, 1, 1, 1, 0, 0, 0, 0},
            '{  2, 0, 0, 1, 1, 0,   0, 0, 406, 304, 1, 1, 1, 0, 0, 0, 0},
            '{  1, 1, 0, 0, 0, 0,   0, 0, 398, 298, 0, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 1, 0, 0, 0,   0, 0, 398, 298, 0, 1, 0, 0, 0, 0, 0},
            '{ 60, 0, 0, 1, 0, 0,   0, 0, 398, 298, 0, 1, 0, 0, 0, 0, 0},
            '{179, 0, 0, 1, 0, 0,   0, 0,  40, 477, 0, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 0, 0, 476, 0,  38, 478, 1, 0, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 0, 0,   0, 0,  40, 476, 1, 0, 0, 0, 0, 0, 0},
            '{237, 0, 0, 1, 0, 0,   0, 0, 514,   2, 1, 0, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 0, 0,   0, 0, 516,   0, 1, 1, 0, 0, 0, 0, 0},
            '{  1, 0, 0, 1, 0, 0,   0, 0, 518,   2, 1, 1, 0, 0, 0, 0, 0}
        };

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                step(vecs[i].rst != 0, vecs[i].start != 0, vecs[i].tick != 0,
                     vecs[i].sdir != 0, vecs[i].lvl, vecs[i].py1, vecs[i].py2);
            end
            chk($sformatf("vec%0d.ball_x", i), ball_x, vecs[i].ex);
            chk($sformatf("vec%0d.ball_y", i), ball_y, vecs[i].ey);
            chk($sformatf("vec%0d.right", i), right, vecs[i].er);
            chk($sformatf("vec%0d.down", i), down, vecs[i].ed);
            chk($sformatf("vec%0d.score1", i), score1, vecs[i].s1);
            chk($sformatf("vec%0d.score2", i), score2, vecs[i].s2);
            chk($sformatf("vec%0d.point_p1", i), point_p1, vecs[i].pp1);
            chk($sformatf("vec%0d.point_p2", i), point_p2, vecs[i].pp2);
            chk($sformatf("vec%0d.game_over", i), game_over, vecs[i].go);
        end

        // P2 wins every rally (P1 paddle parked out of the ball's path) up to game end.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            repeat (60) step(0, 0, 1, 0, 0, 0, 0);
            repeat (199) step(0, 0, 1, 0, 0, 0, 0);
            chk($sformatf("miss%0d.ball_x", k), ball_x, 0);
            chk($sformatf("miss%0d.ball_y", k), ball_y, 497);
            step(0, 0, 1, 0, 0, 0, 0);
            chk($sformatf("miss%0d.score2", k), score2, k);
            chk($sformatf("miss%0d.score1", k), score1, 0);
            chk($sformatf("miss%0d.point_p2", k), point_p2, 1);
            chk($sformatf("miss%0d.serve_right", k), right, 0);
            chk($sformatf("miss%0d.game_over", k), game_over, k == 7);
            step(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("miss%0d.pulse_clear", k), point_p2, 0);
        end
        repeat (5) step(0, 0, 1, 1, 0, 0, 0);
        chk("over.hold", game_over, 1);
        chk("over.score2_sat", score2, 7);
        step(0, 1, 0, 1, 0, 0, 0);
        chk("restart.score2", score2, 0);
        chk("restart.game_over", game_over, 0);
        chk("restart.right", right, 1);
        chk("restart.ball_x", ball_x, 398);

        // Randomized play, paddles often placed near the ball to provoke hits.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20000; c++) begin
            r   = ($urandom_range(0, 3999) == 0);
            st  = ($urandom_range(0, 39) == 0);
            tk  = ($urandom_range(0, 9) < 6);
            sd  = $urandom_range(0, 1);
            lvl = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 7) begin
                p1 = m_y - int'($urandom_range(0, 50));
                p2 = m_y - int'($urandom_range(0, 50));
                if (p1 < 0) p1 = 0;
                if (p2 < 0) p2 = 0;
            end else begin
                p1 = $urandom_range(0, 600);
                p2 = $urandom_range(0, 600);
            end
            step(r, st, tk, sd, lvl, p1, p2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
